// File: rtl/proc_pkg.sv
// Shared definitions for the bus processor and its instruction sequencer.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package proc_pkg;

    // Opcodes understood by proc
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MOVE = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SUB  = 2'b11;

    // Instruction word layout: {F, Rx, Ry, Data}
    localparam int WORD_W   = 14;
    localparam int FIELD_W  = 2;
    localparam int DATA_W   = 8;
    localparam int F_LSB    = 12;
    localparam int RX_LSB   = 10;
    localparam int RY_LSB   = 8;
    localparam int DATA_LSB = 0;

    typedef struct packed {
        logic [FIELD_W-1:0] f;
        logic [FIELD_W-1:0] rx;
        logic [FIELD_W-1:0] ry;
        logic [DATA_W-1:0]  data;
    } instr_t;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERROR = 2'd3
    } seq_state_t;

    // Split a raw program word into its fields
    function automatic instr_t decode_word(input logic [WORD_W-1:0] word);
        instr_t i;
        i.f    = word[F_LSB    +: FIELD_W];
        i.rx   = word[RX_LSB   +: FIELD_W];
        i.ry   = word[RY_LSB   +: FIELD_W];
        i.data = word[DATA_LSB +: DATA_W];
        return i;
    endfunction

endpackage

// File: rtl/prog_ram.sv
// Program buffer: DEPTH x 14-bit words, synchronous write, asynchronous read.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; writes are gated by the owner.
module prog_ram
    import proc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_word
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_word;
        end
    end

    assign rd_word = mem[rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// Issues a stored program to proc one instruction at a time with a per-instruction watchdog.
// Latency: Start -> w one cycle later; Done -> next w one cycle later; last Done -> Finished one cycle later.
// Backpressure: each instruction is held until proc raises Done; Start/LoadEn are ignored while busy.
module instr_sequencer
    import proc_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              LoadEn,
    input  logic [AW-1:0]     LoadAddr,
    input  logic [WORD_W-1:0] LoadWord,
    input  logic              Start,
    input  logic [AW-1:0]     LastAddr,
    input  logic              Done,
    output logic [1:0]        F,
    output logic [1:0]        Rx,
    output logic [1:0]        Ry,
    output logic [7:0]        Data,
    output logic              w,
    output logic              Busy,
    output logic [AW-1:0]     Pc,
    output logic              Finished,
    output logic              Error
);

    localparam int WD_W = $clog2(TIMEOUT);

    seq_state_t        state, state_nx;
    logic [AW-1:0]     pc_q, pc_nx;
    logic [AW-1:0]     last_q, last_nx;
    logic [AW-1:0]     rd_addr;
    instr_t            ir_q, ir_nx;
    logic [WD_W-1:0]   wd_q, wd_nx;
    logic              fin_q, fin_nx;
    logic              err_q, err_nx;
    logic              can_accept;
    logic              ram_we;
    logic [WORD_W-1:0] rd_word;

    // Loads and launches are only accepted while no program is in flight
    assign can_accept = (state == ST_IDLE) || (state == ST_ERROR);
    assign ram_we     = LoadEn && can_accept;

    prog_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_ram (
        .clk     (Clock),
        .wr_en   (ram_we),
        .wr_addr (LoadAddr),
        .wr_word (LoadWord),
        .rd_addr (rd_addr),
        .rd_word (rd_word)
    );

    // State and datapath registers; reset returns everything to an idle, zeroed sequencer
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= ST_IDLE;
            pc_q   <= '0;
            last_q <= '0;
            ir_q   <= '0;
            wd_q   <= '0;
            fin_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            pc_q   <= pc_nx;
            last_q <= last_nx;
            ir_q   <= ir_nx;
            wd_q   <= wd_nx;
            fin_q  <= fin_nx;
            err_q  <= err_nx;
        end
    end

    // Next-state logic; the single read port is pointed at word 0 when launching
    // and at the following word while waiting, so IR only loads on entry to ISSUE.
    // The watchdog fires when the post-increment count reaches TIMEOUT-1, which
    // lands ERROR exactly TIMEOUT cycles after the ISSUE cycle.
    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        last_nx  = last_q;
        ir_nx    = ir_q;
        wd_nx    = wd_q;
        fin_nx   = 1'b0;
        err_nx   = err_q;
        rd_addr  = '0;
        case (state)
            ST_IDLE, ST_ERROR: begin
                if (Start) begin
                    pc_nx    = '0;
                    last_nx  = LastAddr;
                    err_nx   = 1'b0;
                    ir_nx    = decode_word(rd_word);
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_nx    = '0;
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                rd_addr = pc_q + AW'(1);
                if (Done) begin
                    if (pc_q != last_q) begin
                        pc_nx    = pc_q + AW'(1);
                        ir_nx    = decode_word(rd_word);
                        state_nx = ST_ISSUE;
                    end else begin
                        fin_nx   = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end else begin
                    wd_nx = wd_q + WD_W'(1);
                    if (wd_q == WD_W'(TIMEOUT - 2)) begin
                        err_nx   = 1'b1;
                        state_nx = ST_ERROR;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign w        = (state == ST_ISSUE);
    assign Busy     = (state == ST_ISSUE) || (state == ST_WAIT);
    assign Pc       = pc_q;
    assign Finished = fin_q;
    assign Error    = err_q;
    assign F        = ir_q.f;
    assign Rx       = ir_q.rx;
    assign Ry       = ir_q.ry;
    assign Data     = ir_q.data;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Upstream feeder for the 4-register bus processor `proc`. Holds a small program of `{F, Rx, Ry, Data}` instruction words and issues them one at a time to the processor. For each word it asserts `w` for one cycle and holds `F/Rx/Ry/Data` stable until the processor's `Done`, then advances. It adds a per-instruction watchdog and a program-complete pulse so a controller can launch and monitor whole programs.

## Interface
Parameters:
- `DEPTH`, 16: program buffer entries.
- `AW`, 4: address width; `DEPTH` = 2^`AW`.
- `TIMEOUT`, 15: maximum WAIT cycles without `Done` before error; minimum 4.

Ports:
- `Clock`  in  1  single clock, rising edge.
- `Reset`  in  1  synchronous, active-high; shared with `proc`.
- `LoadEn`  in  1  write `LoadWord` into buffer at `LoadAddr`; honoured only in IDLE or ERROR.
- `LoadAddr`  in  AW  write address.
- `LoadWord`  in  14  `{F[13:12], Rx[11:10], Ry[9:8], Data[7:0]}`.
- `Start`  in  1  begin execution at address 0; honoured only in IDLE or ERROR.
- `LastAddr`  in  AW  address of the final instruction; sampled on accepted `Start`.
- `Done`  in  1  from `proc`.
- `F`, `Rx`, `Ry`  out  2 each  instruction fields to `proc`.
- `Data`  out  8  immediate operand to `proc`.
- `w`  out  1  one-cycle issue strobe to `proc`.
- `Busy`  out  1  high in ISSUE and WAIT.
- `Pc`  out  AW  address of the current instruction.
- `Finished`  out  1  one-cycle pulse after the last instruction's `Done`.
- `Error`  out  1  sticky watchdog flag.

## Operation
- States:
  - IDLE: `w`=0.
  - ISSUE: `w`=1, lasts exactly one cycle.
  - WAIT: wait for `Done` while counting.
  - ERROR: sticky.
- IDLE/ERROR + `Start`:
  - `Pc`←0, `last`←`LastAddr`, `Error`←0.
  - Instruction register (IR) ← buf[0].
  - Go to ISSUE.
- ISSUE: go to WAIT unconditionally; watchdog counter ←0.
- WAIT + `Done`, `Pc`≠`last`: `Pc`←`Pc`+1, IR←buf[`Pc`+1], go to ISSUE.
- WAIT + `Done`, `Pc`=`last`: `Finished`←1 for one cycle, go to IDLE; `Pc` holds.
- WAIT without `Done`: counter increments. If counter = `TIMEOUT`−1 on this cycle, `Error`←1 and go to ERROR.
- `F/Rx/Ry/Data` always come from IR. IR changes only on entry to ISSUE, so the fields are stable from the `w` cycle through the `Done` cycle.
- `Done` seen in IDLE, ISSUE or ERROR is ignored.
- `Start` or `LoadEn` while `Busy` is ignored; the buffer is not modified.
- `LoadEn` and `Start` in the same IDLE cycle: the write occurs. Buf[0] for that `Start` is the pre-write value unless `LoadAddr`≠0.
- `LastAddr`=0 gives a one-instruction program.
- `Pc` never wraps: execution ends at `last` ≤ `DEPTH`−1.
- Buffer contents are not cleared by `Reset`.

## Timing
- Reset values:
  - state IDLE.
  - `w`=0, `Busy`=0, `Finished`=0, `Error`=0.
  - `Pc`=0, IR=0, so `F/Rx/Ry/Data`=0.
- All outputs are registered or decoded from state only; there is no combinational path from `Done`, `Start` or `LoadEn` to outputs.
- `Start` sampled at edge k → `w`=1 in cycle k+1.
- `Done` high in cycle j → next `w`=1 in cycle j+1.
- Against `proc`:
  - load/move completes in 2 cycles per instruction (`w`, then `Done`).
  - add/sub completes in 4 cycles per instruction.
- `Finished` is high in cycle j+1 after the final `Done` in cycle j.
- Reset mid-program: state IDLE on the next edge, `w` forced low that cycle, no `Finished`. `proc` is reset by the same `Reset`.

## Structure
- Shared package `proc_pkg`:
  - opcode constants LOAD=2'b00, MOVE=2'b01, ADD=2'b10, SUB=2'b11.
  - field positions and width of `LoadWord`.
  - sequencer state encoding.
- Sub-module `prog_ram`: `DEPTH`×14, synchronous write, asynchronous read. The FSM, `Pc`, IR and watchdog stay in `instr_sequencer`.

## Test plan
- Load buf[0]={LOAD,R0,–,8'h05}, buf[1]={LOAD,R1,–,8'h03}, buf[2]={ADD,R0,R1}; `LastAddr`=2; `Start`, with real `proc` attached:
  - `w` pulses in cycles 1, 3, 5.
  - `Finished` in cycle 9.
  - R0=8'h08.
- Same program with buf[2]=SUB: R0=8'h02. Check `F/Rx/Ry/Data` are constant between each `w` and its `Done`.
- `Done` tied low: `Error`=1 and state ERROR exactly `TIMEOUT` cycles after the ISSUE cycle. A subsequent `Start` clears `Error` and reruns from `Pc`=0.
- While `Busy`, pulse `Start` and `LoadEn` (addr 1, word 14'h3FFF): no restart; after `Finished`, buf[1] is unchanged.
- `Reset` asserted during the WAIT of instruction 1: next cycle `w`=0, `Busy`=0, `Pc`=0, `F/Rx/Ry/Data`=0, no `Finished`. `Start` then runs normally.
- `LastAddr`=0 with a single MOVE: exactly one `w`, `Finished` 2 cycles after `w`.
